// File: rtl/mtf_pkg.sv
// mtf_pkg: shared sizes and token type for the move-to-front decoder.
package mtf_pkg;
   localparam int MTF_DEPTH  = 4;
   localparam int MTF_IDX_W  = 2;
   localparam int MTF_DATA_W = 8;
   typedef struct packed {
      logic                  is_ref;
      logic [MTF_IDX_W-1:0]  idx;
      logic [MTF_DATA_W-1:0] data;
   } mtf_tok_t;
endpackage

// File: rtl/mtf_table.sv
// mtf_table: four-entry most-recent-first table with hit detect, lookup and move-to-front update.
module mtf_table
   import mtf_pkg::*;
#(
   parameter int DATA_W = MTF_DATA_W
) (
   input  logic                                clk_in,
   input  logic                                reset_n_in,
   input  logic                                upd_i,
   input  logic [DATA_W-1:0]                   val_i,
   input  logic [MTF_IDX_W-1:0]                idx_i,
   output logic [DATA_W-1:0]                   rd_data_o,
   output logic                                rd_valid_o,
   output logic                                hit_o,
   output logic [MTF_IDX_W-1:0]                hit_idx_o,
   output logic [MTF_DEPTH-1:0][DATA_W-1:0]    entries_o,
   output logic [MTF_DEPTH-1:0]                valid_o
);
   logic [MTF_DEPTH-1:0][DATA_W-1:0] ent_q, ent_d;
   logic [MTF_DEPTH-1:0]             vld_q, vld_d;
   logic [MTF_IDX_W-1:0]             stop;

   assign rd_data_o  = ent_q[idx_i];
   assign rd_valid_o = vld_q[idx_i];
   assign entries_o  = ent_q;
   assign valid_o    = vld_q;

   // descending scan so the lowest matching slot wins
   always_comb begin
      hit_o     = 1'b0;
      hit_idx_o = '0;
      for (int k = MTF_DEPTH - 1; k >= 0; k--)
         if (vld_q[k] && ent_q[k] == val_i) begin
            hit_o     = 1'b1;
            hit_idx_o = MTF_IDX_W'(k);
         end
   end

   // a miss behaves like a hit on the last slot, plus the fill-flag shift
   assign stop = hit_o ? hit_idx_o : MTF_IDX_W'(MTF_DEPTH - 1);

   always_comb begin
      ent_d = ent_q;
      vld_d = vld_q;
      if (upd_i) begin
         for (int i = 1; i < MTF_DEPTH; i++)
            if (i <= int'(stop)) ent_d[i] = ent_q[i-1];
         ent_d[0] = val_i;
         vld_d    = hit_o ? vld_q : {vld_q[MTF_DEPTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in)
      if (!reset_n_in) begin
         ent_q <= '0;
         vld_q <= '0;
      end else begin
         ent_q <= ent_d;
         vld_q <= vld_d;
      end
endmodule

// File: rtl/mtf_decoder.sv
// mtf_decoder: move-to-front token decoder with registered output, handshake and error pulse.
module mtf_decoder
   import mtf_pkg::*;
#(
   parameter int DATA_W = MTF_DATA_W
) (
   input  logic              clk_in,
   input  logic              reset_n_in,
   input  logic              tok_valid_in,
   output logic              tok_ready_out,
   input  logic              tok_is_ref_in,
   input  logic [1:0]        tok_idx_in,
   input  logic [DATA_W-1:0] tok_data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid_out,
   input  logic              data_ready_in,
   output logic [DATA_W-1:0] entry_0,
   output logic [DATA_W-1:0] entry_1,
   output logic [DATA_W-1:0] entry_2,
   output logic [DATA_W-1:0] entry_3,
   output logic              entry_valid_0,
   output logic              entry_valid_1,
   output logic              entry_valid_2,
   output logic              entry_valid_3,
   output logic              err_out
);
   mtf_tok_t                         tok;
   logic [DATA_W-1:0]                data_q, data_d, val, rd_data;
   logic                             dv_q, dv_d, err_q, err_d;
   logic                             acc, upd, rd_valid, hit;
   logic [MTF_IDX_W-1:0]             hit_idx;
   logic [MTF_DEPTH-1:0][DATA_W-1:0] ents;
   logic [MTF_DEPTH-1:0]             vlds;

   assign tok = '{is_ref: tok_is_ref_in, idx: tok_idx_in, data: tok_data_in};

   assign tok_ready_out = !dv_q || data_ready_in;
   assign acc           = tok_valid_in && tok_ready_out;
   assign val           = tok.is_ref ? rd_data : tok.data;
   // an index into an unfilled slot is swallowed: no output, no table change
   assign upd           = acc && (!tok.is_ref || rd_valid);

   always_comb begin
      data_d = upd ? val : data_q;
      dv_d   = upd ? 1'b1 : (data_ready_in ? 1'b0 : dv_q);
      err_d  = acc && tok.is_ref && !rd_valid;
   end

   always_ff @(posedge clk_in or negedge reset_n_in)
      if (!reset_n_in) begin
         data_q <= '0;
         dv_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         dv_q   <= dv_d;
         err_q  <= err_d;
      end

   mtf_table #(.DATA_W(DATA_W)) u_table (
      .clk_in     (clk_in),
      .reset_n_in (reset_n_in),
      .upd_i      (upd),
      .val_i      (val),
      .idx_i      (tok.idx),
      .rd_data_o  (rd_data),
      .rd_valid_o (rd_valid),
      .hit_o      (hit),
      .hit_idx_o  (hit_idx),
      .entries_o  (ents),
      .valid_o    (vlds)
   );

   assign data_out       = data_q;
   assign data_valid_out = dv_q;
   assign err_out        = err_q;
   assign entry_0        = ents[0];
   assign entry_1        = ents[1];
   assign entry_2        = ents[2];
   assign entry_3        = ents[3];
   assign entry_valid_0  = vlds[0];
   assign entry_valid_1  = vlds[1];
   assign entry_valid_2  = vlds[2];
   assign entry_valid_3  = vlds[3];
endmodule

// File: tb/tb_mtf_decoder.sv
// tb_mtf_decoder: directed and random checks of mtf_decoder against a queue-based table model.
module tb_mtf_decoder;
   logic       clk = 1'b0, reset_n_in = 1'b0;
   logic       tok_valid_in = 1'b0, tok_is_ref_in = 1'b0, data_ready_in = 1'b1;
   logic [1:0] tok_idx_in = '0;
   logic [7:0] tok_data_in = '0;
   logic       tok_ready_out, data_valid_out, err_out;
   logic [7:0] data_out, e0, e1, e2, e3;
   logic       ev0, ev1, ev2, ev3;
   logic [7:0] ent [4];
   logic       ev [4];
   int         checks = 0, errors = 0;

   logic [7:0] mq [$];
   logic [7:0] m_dout;
   logic       m_dv, m_err;

   always #5 clk = ~clk;

   assign ent[0] = e0; assign ent[1] = e1; assign ent[2] = e2; assign ent[3] = e3;
   assign ev[0] = ev0; assign ev[1] = ev1; assign ev[2] = ev2; assign ev[3] = ev3;

   mtf_decoder #(.DATA_W(8)) dut (
      .clk_in(clk), .reset_n_in(reset_n_in),
      .tok_valid_in(tok_valid_in), .tok_ready_out(tok_ready_out),
      .tok_is_ref_in(tok_is_ref_in), .tok_idx_in(tok_idx_in), .tok_data_in(tok_data_in),
      .data_out(data_out), .data_valid_out(data_valid_out), .data_ready_in(data_ready_in),
      .entry_0(e0), .entry_1(e1), .entry_2(e2), .entry_3(e3),
      .entry_valid_0(ev0), .entry_valid_1(ev1), .entry_valid_2(ev2), .entry_valid_3(ev3),
      .err_out(err_out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("data_out", 32'(data_out), 32'(m_dout));
      chk("data_valid", 32'(data_valid_out), 32'(m_dv));
      chk("err", 32'(err_out), 32'(m_err));
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("entry_%0d", i), 32'(ent[i]), i < mq.size() ? 32'(mq[i]) : 32'h0);
         chk($sformatf("entry_valid_%0d", i), 32'(ev[i]), 32'(i < mq.size()));
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_err  = 1'b0;
   endtask

   // one clock edge of the decoder, expressed as list operations on the recent-value list
   task automatic model_edge(input logic v, input logic r, input logic is_ref,
                             input logic [1:0] idx, input logic [7:0] d);
      logic       acc, emitted;
      logic [7:0] val;
      int         pos;
      acc     = v && (!m_dv || r);
      emitted = 1'b0;
      m_err   = 1'b0;
      if (acc) begin
         if (is_ref && int'(idx) >= mq.size()) m_err = 1'b1;
         else begin
            val = is_ref ? mq[idx] : d;
            pos = -1;
            foreach (mq[j]) if (pos < 0 && mq[j] == val) pos = j;
            if (pos >= 0) mq.delete(pos);
            mq.push_front(val);
            if (mq.size() > 4) void'(mq.pop_back());
            m_dout  = val;
            emitted = 1'b1;
         end
      end
      if (emitted) m_dv = 1'b1;
      else if (r) m_dv = 1'b0;
   endtask

   task automatic cyc(input logic v, input logic r, input logic is_ref,
                      input logic [1:0] idx, input logic [7:0] d);
      tok_valid_in  = v;
      data_ready_in = r;
      tok_is_ref_in = is_ref;
      tok_idx_in    = idx;
      tok_data_in   = d;
      #1;
      chk("tok_ready", 32'(tok_ready_out), 32'(!m_dv || r));
      @(posedge clk);
      model_edge(v, r, is_ref, idx, d);
      #1;
      check_all();
   endtask

   task automatic exp_tab(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
      chk("tab0", 32'(e0), 32'(a));
      chk("tab1", 32'(e1), 32'(b));
      chk("tab2", 32'(e2), 32'(c));
      chk("tab3", 32'(e3), 32'(d));
   endtask

   task automatic do_reset();
      tok_valid_in = 1'b0;
      reset_n_in   = 1'b0;
      #1;
      model_clear();
      check_all();
      chk("rst_ready", 32'(tok_ready_out), 32'h1);
      @(posedge clk);
      #1;
      reset_n_in = 1'b1;
   endtask

   initial begin
      model_clear();
      do_reset();

      cyc(1, 1, 0, 0, 8'h11);
      cyc(1, 1, 0, 0, 8'h22);
      cyc(1, 1, 0, 0, 8'h33);
      cyc(1, 1, 0, 0, 8'h44);
      chk("lit_dout", 32'(data_out), 32'h44);
      exp_tab(8'h44, 8'h33, 8'h22, 8'h11);
      chk("lit_allvalid", 32'({ev0, ev1, ev2, ev3}), 32'hf);

      cyc(1, 1, 1, 2, 8'h00);
      chk("idx2_dout", 32'(data_out), 32'h22);
      exp_tab(8'h22, 8'h44, 8'h33, 8'h11);
      cyc(1, 1, 1, 0, 8'h00);
      chk("idx0_dout", 32'(data_out), 32'h22);
      exp_tab(8'h22, 8'h44, 8'h33, 8'h11);

      cyc(1, 1, 0, 0, 8'h33);
      exp_tab(8'h33, 8'h22, 8'h44, 8'h11);
      cyc(1, 1, 0, 0, 8'h55);
      exp_tab(8'h55, 8'h33, 8'h22, 8'h44);

      cyc(1, 1, 0, 0, 8'h66);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0, 8'h77);
         chk("bp_ready", 32'(tok_ready_out), 32'h0);
         chk("bp_hold", 32'(data_out), 32'h66);
         exp_tab(8'h66, 8'h55, 8'h33, 8'h22);
      end
      cyc(1, 1, 0, 0, 8'h77);
      chk("bp_resume", 32'(data_out), 32'h77);
      cyc(1, 1, 0, 0, 8'h88);
      chk("bp_next", 32'(data_out), 32'h88);

      do_reset();
      cyc(1, 1, 0, 0, 8'hAA);
      cyc(1, 1, 1, 1, 8'h00);
      chk("inv_err", 32'(err_out), 32'h1);
      chk("inv_nodv", 32'(data_valid_out), 32'h0);
      exp_tab(8'hAA, 8'h00, 8'h00, 8'h00);
      chk("inv_vld", 32'({ev0, ev1, ev2, ev3}), 32'h8);
      cyc(0, 1, 0, 0, 8'h00);
      chk("inv_pulse_end", 32'(err_out), 32'h0);

      for (int n = 0; n < 400; n++)
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 8'($urandom_range(0, 9)) * 8'h11);

      cyc(1, 1, 0, 0, 8'h99);
      #2;
      reset_n_in = 1'b0;
      #1;
      chk("mid_rst_dout", 32'(data_out), 32'h0);
      chk("mid_rst_dv", 32'(data_valid_out), 32'h0);
      chk("mid_rst_e0", 32'(e0), 32'h0);
      chk("mid_rst_v0", 32'(ev0), 32'h0);
      do_reset();
      cyc(1, 1, 0, 0, 8'h11);
      exp_tab(8'h11, 8'h00, 8'h00, 8'h00);
      chk("mid_rst_vld", 32'({ev0, ev1, ev2, ev3}), 32'h8);

      for (int n = 0; n < 200; n++)
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
             2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mtf_decoder.md
# mtf_decoder

Move-to-front decoder for the four-entry recent-distinct-value stream. It accepts tokens that carry either a literal value or a 2-bit index into a four-entry most-recent-first table of distinct values. It emits the reconstructed data stream and updates the table exactly as the distinct-value tracker on the producing side does, so both ends hold identical tables after every symbol. It sits downstream of the link, in front of the consumer of raw `DATA_W` samples.

## Interface
- `DATA_W`, 8, width of data values and table entries
- `clk_in`  input  1  clock; all state changes on its rising edge
- `reset_n_in`  input  1  asynchronous, active-low reset
- `tok_valid_in`  input  1  token present
- `tok_ready_out`  output  1  decoder accepts a token this cycle
- `tok_is_ref_in`  input  1  1 = index token, 0 = literal token
- `tok_idx_in`  input  2  table index; used only when `tok_is_ref_in`=1
- `tok_data_in`  input  `DATA_W`  literal value; used only when `tok_is_ref_in`=0
- `data_out`  output  `DATA_W`  decoded value
- `data_valid_out`  output  1  `data_out` holds a valid symbol
- `data_ready_in`  input  1  consumer accepts `data_out`
- `entry_0`…`entry_3`  output  `DATA_W` each  table contents, most recent first
- `entry_valid_0`…`entry_valid_3`  output  1 each  per-entry fill flags
- `err_out`  output  1  one-cycle pulse when an index token hits an unfilled entry

## Operation
- **Accept:** a token is accepted when `tok_valid_in` and `tok_ready_out` are both 1. `tok_ready_out` = !`data_valid_out` || `data_ready_in`.
- **Decoded value V:**
  - Literal token: V = `tok_data_in`.
  - Index token with `entry_valid_k` = 1: V = `entry_k`, where k = `tok_idx_in`.
- **Hit:** V equals some valid `entry_k`. Only the lowest such k matters; entries are distinct by construction.
  - Entries 0..k-1 shift down one slot.
  - V goes to slot 0.
  - Entries above k are unchanged.
  - Valid flags are unchanged.
  - An index token is always a hit.
- **Miss** (literal only): all entries shift down one slot, entry 3 is dropped, and V goes to slot 0. `entry_valid_0` ← 1 and each `entry_valid_i` ← `entry_valid_(i-1)`.
- **Hit at k=0:** table unchanged; V is still emitted.
- **Invalid index** (`entry_valid_k` = 0):
  - The token is consumed.
  - Nothing is emitted and the table is unchanged.
  - `err_out` = 1 for one cycle.
- **Output register:** on each accept producing V, `data_out` ← V and `data_valid_out` ← 1. Otherwise `data_valid_out` ← 0 when `data_ready_in` = 1, and `data_out` holds its value.
- **Reset values:**
  - Async assert clears `data_out`, `data_valid_out`, `err_out`, all entries and all valid flags to 0.
  - Reset mid-stream discards the held output and the table; the producer must reset together.
  - Release is sampled on the next clock edge.

## Timing
- Latency: token accepted at edge N gives `data_out` valid from edge N, i.e. visible in cycle N+1. The table updates at the same edge N.
- Throughput is one token per cycle while `data_ready_in` stays 1.
- Back-to-back tokens see the table as updated by the previous token; there is no bypass hazard.
- While `data_valid_out` = 1 and `data_ready_in` = 0: `tok_ready_out` = 0, and `data_out`, `data_valid_out` and the table are held.
- `err_out` is registered: it asserts the cycle after the offending accept and lasts exactly one cycle.
- `entry_*` outputs are the registered table state; no combinational path runs from token inputs to them.

## Structure
- Package `mtf_pkg` holds:
  - `MTF_DEPTH` = 4 and `MTF_IDX_W` = 2.
  - The token struct {is_ref, idx, data}, parameterised by `DATA_W` via a localparam default of 8.
- Sub-module `mtf_table` holds the four entries and their valid flags.
  - Combinational: hit detect and hit index, lookup by index.
  - Sequential: the move-to-front / insert update.
  - The top level keeps the handshake, the output register and the error pulse.

## Test plan
- **Reset then literals:** reset, then literals 0x11, 0x22, 0x33, 0x44 → `data_out` 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Final table entry_0..3 = 0x44, 0x33, 0x22, 0x11, all valid.
- **Index move-to-front:** from that table, index 2 → `data_out` 0x22, table 0x22, 0x44, 0x33, 0x11. Then index 0 → 0x22, table unchanged.
- **Literal hit and miss:**
  - Literal 0x33 (hit at k=2) → table 0x33, 0x22, 0x44, 0x11.
  - Literal 0x55 (miss) → table 0x55, 0x33, 0x22, 0x44; 0x11 is dropped.
- **Invalid index:** after reset, literal 0xAA, then index 1 → `err_out` pulses for one cycle. There is no `data_valid_out` for that token, and the table stays 0xAA with `entry_valid_0` only.
- **Backpressure:** hold `data_ready_in` = 0 for 3 cycles with `tok_valid_in` = 1 → `tok_ready_out` = 0, while `data_out` and the table stay stable. On release, tokens resume one per cycle with no loss or duplication.
- **Mid-stream reset:** assert `reset_n_in` asynchronously mid-stream → all outputs are 0 immediately, before the next edge. After release, literal 0x11 gives table 0x11 with only `entry_valid_0` set.
